fifo_word_packer: RTL and testbench

- Consumer on the read port of the team's 32x8 synchronous FIFO.
- Pulls bytes with the FIFO's read/empty handshake and packs NBYTES consecutive bytes, little-endian, into one output word.
- Presents each word downstream on a valid/ready interface.
- Counterpart to the FIFO's write side: drains the buffer into a wider datapath.

---
 rtl/fifo_word_packer.sv | 162 ++++++++++++++++
 tb/tb_fifo_word_packer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: drains the byte-wide FIFO read port and packs NBYTES
// consecutive bytes, little-endian, into one word on a valid/ready interface.
// The first byte read lands in word_data[7:0].
// Optional feature: define FLUSH_TIMEOUT_EN to flush a partial word after
// TIMEOUT idle cycles. Flushed words have unfilled lanes at zero and
// word_be set only for the captured lanes.
module fifo_word_packer #(
  parameter int NBYTES  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic [7:0]            fifo_data,
  output logic [8*NBYTES-1:0]   word_data,
  output logic [NBYTES-1:0]     word_be,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  busy
);

  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW:0]   NB_EXT = (CW + 1)'(NBYTES);
  localparam logic [CW-1:0] NB_CNT = CW'(NBYTES);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_e;

  // Reject illegal parameter values at elaboration time.
  if (NBYTES < 2 || NBYTES > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("fifo_word_packer: NBYTES must be 2..8 and TIMEOUT 1..255");
  end

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [8*NBYTES-1:0] data_q, data_d;
  logic [NBYTES-1:0]   be_q, be_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [CW:0]         inflight_s;

`ifdef FLUSH_TIMEOUT_EN
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);
  logic [7:0] idle_q, idle_d;
`endif

  // Read request: only while filling, FIFO non-empty, and a lane is free
  // once the in-flight byte is counted.
  always_comb begin
    inflight_s = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};
    fifo_read  = (state_q == S_FILL) & ~fifo_empty & (inflight_s < NB_EXT);
  end

  // Next-state logic: byte capture, word completion, transfer and flush.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    be_d      = be_q;
    valid_d   = valid_q;
    rd_pend_d = fifo_read;
`ifdef FLUSH_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    case (state_q)
      S_FILL: begin
        if (rd_pend_q) begin
          for (int k = 0; k < NBYTES; k++) begin
            if (CW'(k) == cnt_q) begin
              data_d[8*k +: 8] = fifo_data;
            end else begin
              data_d[8*k +: 8] = data_q[8*k +: 8];
            end
          end
          cnt_d = cnt_q + CW'(1'b1);
`ifdef FLUSH_TIMEOUT_EN
          idle_d = 8'd0;
`endif
          if (cnt_d == NB_CNT) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            be_d    = {NBYTES{1'b1}};
          end else begin
            state_d = S_FILL;
          end
        end
`ifdef FLUSH_TIMEOUT_EN
        else if ((cnt_q != {CW{1'b0}}) && fifo_empty) begin
          idle_d = idle_q + 8'd1;
          if (idle_d == TO_CNT) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
            for (int k = 0; k < NBYTES; k++) begin
              be_d[k] = (CW'(k) < cnt_q);
            end
          end else begin
            state_d = S_FILL;
          end
        end
`endif
        else begin
          state_d = S_FILL;
        end
      end
      S_HOLD: begin
        if (valid_q & word_ready) begin
          state_d = S_FILL;
          valid_d = 1'b0;
          cnt_d   = {CW{1'b0}};
          data_d  = {(8*NBYTES){1'b0}};
          be_d    = {NBYTES{1'b0}};
`ifdef FLUSH_TIMEOUT_EN
          idle_d  = 8'd0;
`endif
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
    busy_d = (cnt_d != {CW{1'b0}}) | rd_pend_d | valid_d;
  end

  // State and output registers; reset abandons any partial or in-flight byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FILL;
      cnt_q     <= {CW{1'b0}};
      rd_pend_q <= 1'b0;
      data_q    <= {(8*NBYTES){1'b0}};
      be_q      <= {NBYTES{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FLUSH_TIMEOUT_EN
      idle_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      data_q    <= data_d;
      be_q      <= be_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
`ifdef FLUSH_TIMEOUT_EN
      idle_q    <= idle_d;
`endif
    end
  end

  assign word_data  = data_q;
  assign word_be    = be_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer (NBYTES=4, TIMEOUT=16): behavioural FIFO model,
// scoreboard of expected words, table of word vectors plus hand sequences.
module tb_fifo_word_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fifo_empty;
  logic        fifo_read;
  logic [7:0]  fifo_data;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        word_ready;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int          wait_cyc;
    bit          gap;
    logic [31:0] exp_word;
  } vec_t;

  logic [7:0] fq[$];
  exp_t       sb[$];
  vec_t       vecs[5];

  bit          gap_en    = 1'b0;
  bit          gap_phase = 1'b0;
  int          hold_wait = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = 32'h0;

  always #5 clock = ~clock;

  fifo_word_packer #(.NBYTES(4), .TIMEOUT(16)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .fifo_data  (fifo_data),
    .word_data  (word_data),
    .word_be    (word_be),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered FIFO model: an accepted read presents data the next cycle.
  initial begin
    forever begin
      @(posedge clock);
      if (fifo_read && fq.size() > 0) fifo_data <= fq.pop_front();
    end
  end

  // Monitor: handshake rules, hold stability and scoreboard comparison.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (fifo_empty) check("no_read_when_empty", 64'(fifo_read), 64'h0);
        if (word_valid) check("no_read_in_hold", 64'(fifo_read), 64'h0);
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 64'(word_valid), 64'h1);
          check("hold_data", 64'(word_data), 64'(prev_data));
        end
        if (word_valid && word_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h expected none", word_data);
          end else begin
            check("word_data", 64'(word_data), 64'(sb[0].data));
            check("word_be", 64'(word_be), 64'(sb[0].be));
            void'(sb.pop_front());
          end
        end
        prev_valid <= word_valid;
        prev_ready <= word_ready;
        prev_data  <= word_data;
      end else begin
        prev_valid <= 1'b0;
      end
    end
  end

  task automatic upd_empty();
    fifo_empty = (fq.size() == 0) || (gap_en && gap_phase);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    gap_phase = ~gap_phase;
    upd_empty();
    if (word_valid && hold_wait > 0) begin
      word_ready = 1'b0;
      hold_wait--;
    end else begin
      word_ready = 1'b1;
    end
  endtask

  task automatic push4(input logic [7:0] b0, b1, b2, b3);
    fq.push_back(b0);
    fq.push_back(b1);
    fq.push_back(b2);
    fq.push_back(b3);
    upd_empty();
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: %0d words outstanding, required 0", name, sb.size());
      sb.delete();
    end
    tick();
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [9:0] rd_tr;
    logic [9:0] val_tr;
    int         first;
    bit         seen;

    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 1'b0, 32'h44332211};
    vecs[1] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 0, 1'b1, 32'hA3A2A1A0};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 2, 1'b0, 32'h00FF00FF};
    vecs[3] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 5, 1'b1, 32'hEFBEADDE};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h01, 0, 1'b0, 32'h01000000};

    reset_n    = 1'b0;
    fifo_empty = 1'b1;
    word_ready = 1'b1;
    fifo_data  = 8'h00;
    repeat (3) tick();
    check("rst_valid", 64'(word_valid), 64'h0);
    check("rst_be", 64'(word_be), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_data", 64'(word_data), 64'h0);
    check("rst_read", 64'(fifo_read), 64'h0);
    reset_n = 1'b1;
    tick();

    // Streaming: read cycles 0-3, word_valid in cycle 5 only.
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    sb.push_back('{data: 32'h44332211, be: 4'hF});
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      rd_tr[c]  = fifo_read;
      val_tr[c] = word_valid;
      tick();
    end
    check("stream_read_cycles", 64'(rd_tr), 64'h00F);
    check("stream_valid_cycles", 64'(val_tr), 64'h020);
    drain(5, "stream");

    // Table of single words with varying backpressure and empty gaps.
    for (int i = 0; i < 5; i++) begin
      gap_en    = vecs[i].gap;
      hold_wait = vecs[i].wait_cyc;
      push4(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      sb.push_back('{data: vecs[i].exp_word, be: 4'hF});
      drain(60, "vec");
      check("vec_idle_busy", 64'(busy), 64'h0);
      gap_en = 1'b0;
      upd_empty();
    end

    // Backpressure: 10 cycles of word_ready=0 on the first of two words.
    hold_wait = 10;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    sb.push_back('{data: 32'h44332211, be: 4'hF});
    sb.push_back('{data: 32'h88776655, be: 4'hF});
    drain(80, "backpressure");
    check("backpressure_held", 64'(hold_wait), 64'h0);

    // Reset mid-word after two bytes captured.
    fq.push_back(8'hE1);
    fq.push_back(8'hE2);
    upd_empty();
    repeat (3) tick();
    check("midword_busy", 64'(busy), 64'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(word_valid), 64'h0);
    check("midrst_be", 64'(word_be), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    sb.push_back('{data: 32'h04030201, be: 4'hF});
    drain(40, "after_reset");

    // Partial word followed by an empty FIFO.
    fq.push_back(8'hAA);
    fq.push_back(8'hBB);
    upd_empty();
`ifdef FLUSH_TIMEOUT_EN
    sb.push_back('{data: 32'h0000BBAA, be: 4'h3});
    first = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (word_valid && first < 0) first = c;
      tick();
    end
    check("flush_cycle", 64'(first), 64'd19);
    drain(5, "flush");
`else
    first = 0;
    seen  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (word_valid) seen = 1'b1;
      tick();
    end
    check("partial_no_valid", 64'(seen), 64'h0);
    check("partial_busy", 64'(busy), 64'h1);
    fq.push_back(8'hCC);
    fq.push_back(8'hDD);
    upd_empty();
    sb.push_back('{data: 32'hDDCCBBAA, be: 4'hF});
    drain(20, "partial_complete");
    check("partial_first", 64'(first), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
